tt_um_muaz_tttest: RTL and testbench
====================================

// Module: tt_um_muaz_tttest
// PURPOSE
//   TinyTapeout user tile: an 8-bit accumulator ALU driven from the chip pins.
//   ui_in supplies an operand; uio_in[3:0] supply an opcode and an execute strobe.
//   Result on uo_out, status flags on uio_out[7:4]. Top level of the tile; no submodules required.
// PARAMETERS
//   none (fixed 8-bit datapath)
// PORTS
//   clk      in   1  tile clock; all state updates on rising edge
//   rst_n    in   1  reset, synchronous, active-low
//   ena      in   1  tile selected; 0 = freeze all state (outputs still driven)
//   ui_in    in   8  operand D
//   uo_out   out  8  accumulator A
//   uio_in   in   8  [2:0] opcode OP, [3] strobe STB, [7:4] ignored
//   uio_out  out  8  [3:0] = 0; [4] Z, [5] C, [6] N, [7] P (or PWM, see CONFIGURATION)
//   uio_oe   out  8  constant 8'hF0 (uio[7:4] outputs, uio[3:0] inputs)
// BEHAVIOUR
//   - State: A[7:0], C, stb_q (previous STB sample), pwm_cnt[7:0] (only with PWM_OUT_EN).
//   - Reset (rst_n=0 at clk edge): A=0, C=0, stb_q=0, pwm_cnt=0; overrides ena and strobe.
//   - ena=0: no register changes at all (stb_q also held).
//   - ena=1: stb_q <= STB every cycle; exec = STB & ~stb_q (rising edge of STB).
//   - On an edge with exec=1, OP applied; new A visible on uo_out right after that edge
//     (1-cycle latency from the first cycle STB samples high). Holding STB high executes once.
//   - Opcodes (D = ui_in sampled at the exec edge):
//       000 NOP        A,C unchanged
//       001 LOAD       A=D, C=0
//       010 ADD        {C,A} = A + D (9-bit sum)
//       011 SUB        A = A - D mod 256; C = 1 when A < D (borrow)
//       100 AND        A = A & D, C unchanged
//       101 OR         A = A | D, C unchanged
//       110 XOR        A = A ^ D, C unchanged
//       111 ROL        A rotated left by D[2:0] bits; C unchanged; D[2:0]=0 leaves A
//   - Flags (combinational from registers): Z = (A==0), N = A[7], C = register,
//     P = ^A (odd parity, 1 when A has odd number of ones).
//   - uo_out = A directly; uio_out[3:0] = 0 always; uio_oe = 8'hF0 always, including reset.
//   - Inputs treated as synchronous to clk; no synchronizer inside the tile.
// CONFIGURATION
//   PWM_OUT_EN defined: 8-bit pwm_cnt increments each ena=1 cycle, wraps 255->0;
//     uio_out[7] = (pwm_cnt < A) registered-free compare -> duty A/256; A=0 gives constant 0,
//     A=255 gives 255/256 high. P flag is then not exported.
//   PWM_OUT_EN undefined: uio_out[7] = P; no pwm_cnt register exists.
// TESTING
//   1. Reset: rst_n=0 two cycles -> uo_out=0x00, uio_out=0x10 (Z=1, P=0), uio_oe=0xF0.
//   2. LOAD 0x3C (OP=001, pulse STB) -> uo_out=0x3C one edge after STB rises; hold STB 5
//      cycles, change D -> A stays 0x3C.
//   3. LOAD 0xF0, ADD 0x20 -> A=0x10, C=1; SUB 0x11 -> A=0xFF, C=1, N=1, P=0.
//   4. LOAD 0x81, ROL D=0x01 -> A=0x03; XOR 0x03 -> A=0x00, Z=1; AND/OR leave C unchanged.
//   5. ena=0 with STB pulses -> A unchanged; rst_n=0 mid-sequence -> A=0, C=0 next edge.
//   6. PWM_OUT_EN build: LOAD 0x40 -> uio_out[7] high 64 of every 256 ena cycles.

Source files
------------

// File: rtl/tt_um_muaz_tttest.sv
// tt_um_muaz_tttest: 8-bit accumulator ALU tile, operand on ui_in, opcode/strobe on uio_in.
// Optional feature macro PWM_OUT_EN: uio_out[7] becomes a PWM of A instead of parity.
module tt_um_muaz_tttest (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_ROL  = 3'b111
    } op_e;

    logic [7:0]  a_q;
    logic [7:0]  a_d;
    logic        c_q;
    logic        c_d;
    logic        stb_q;
    logic        stb;
    logic        exec;
    op_e         op;
    logic [7:0]  d;
    logic [8:0]  sum;
    logic [8:0]  diff;
    logic [15:0] rot;
    logic        flag_z;
    logic        flag_n;
    logic        flag_7;
    logic        unused_bits;

    assign d    = ui_in;
    assign op   = op_e'(uio_in[2:0]);
    assign stb  = uio_in[3];
    assign exec = stb & ~stb_q;

    assign unused_bits = &{1'b0, uio_in[7:4]};

    // Shared arithmetic: 9-bit add/sub expose carry/borrow in bit 8
    always_comb begin
        sum  = {1'b0, a_q} + {1'b0, d};
        diff = {1'b0, a_q} - {1'b0, d};
        rot  = {a_q, a_q} << d[2:0];
    end

    // Next accumulator and carry; only an STB rising edge applies the opcode
    always_comb begin
        a_d = a_q;
        c_d = c_q;
        if (exec) begin
            unique case (op)
                OP_NOP: begin
                    a_d = a_q;
                end
                OP_LOAD: begin
                    a_d = d;
                    c_d = 1'b0;
                end
                OP_ADD: begin
                    a_d = sum[7:0];
                    c_d = sum[8];
                end
                OP_SUB: begin
                    a_d = diff[7:0];
                    c_d = diff[8];
                end
                OP_AND: begin
                    a_d = a_q & d;
                end
                OP_OR: begin
                    a_d = a_q | d;
                end
                OP_XOR: begin
                    a_d = a_q ^ d;
                end
                OP_ROL: begin
                    a_d = rot[15:8];
                end
            endcase
        end
    end

    // Architectural state; ena=0 freezes everything including the strobe history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= 8'h00;
            c_q   <= 1'b0;
            stb_q <= 1'b0;
        end else if (ena) begin
            a_q   <= a_d;
            c_q   <= c_d;
            stb_q <= stb;
        end
    end

    assign flag_z = (a_q == 8'h00);
    assign flag_n = a_q[7];

`ifdef PWM_OUT_EN
    logic [7:0] pwm_q;

    // Free-running PWM counter, advances only while the tile is enabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_q <= 8'h00;
        end else if (ena) begin
            pwm_q <= pwm_q + 8'd1;
        end
    end

    assign flag_7 = (pwm_q < a_q);
`else
    assign flag_7 = ^a_q;
`endif

    assign uo_out  = a_q;
    assign uio_out = {flag_7, flag_n, c_q, flag_z, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_muaz_tttest.sv
// tb_tt_um_muaz_tttest: accumulator ALU tile bench, directed literals plus random traffic.
// Behavioural model updated at posedge, compared against the DUT on every negedge.
module tb_tt_um_muaz_tttest;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;
    bit check_en = 0;

    int m_a   = 0;
    int m_c   = 0;
    int m_stb = 0;
    int m_pwm = 0;

    tt_um_muaz_tttest dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference model: spec rules as plain integer arithmetic
    always @(posedge clk) begin
        int op;
        int dv;
        int k;
        int s;
        if (!rst_n) begin
            m_a = 0; m_c = 0; m_stb = 0; m_pwm = 0;
        end else if (ena) begin
            op = uio_in & 7;
            dv = ui_in;
            if (uio_in[3] && m_stb == 0) begin
                case (op)
                    1: begin m_a = dv; m_c = 0; end
                    2: begin s = m_a + dv; m_c = (s > 255); m_a = s % 256; end
                    3: begin m_c = (m_a < dv); m_a = (m_a - dv + 256) % 256; end
                    4: m_a = m_a & dv;
                    5: m_a = m_a | dv;
                    6: m_a = m_a ^ dv;
                    7: begin
                        k = dv % 8;
                        if (k != 0)
                            m_a = ((m_a << k) | (m_a >> (8 - k))) % 256;
                    end
                    default: ;
                endcase
            end
            m_stb = uio_in[3];
            m_pwm = (m_pwm + 1) % 256;
        end
    end

    function automatic logic [7:0] model_uio();
        int ones;
        logic b7;
        ones = $countones(m_a[7:0]);
`ifdef PWM_OUT_EN
        b7 = (m_pwm < m_a);
`else
        b7 = (ones % 2) == 1;
`endif
        return {b7, (m_a >= 128), (m_c != 0), (m_a == 0), 4'b0000};
    endfunction

    // Compare process: every negedge once reset has been applied
    always @(negedge clk) begin
        if (check_en) begin
            checks++;
            if (uo_out !== m_a[7:0]) begin
                failures++;
                $display("FAIL model_uo_out t=%0t got=%h exp=%h", $time, uo_out, m_a[7:0]);
            end
            checks++;
            if (uio_out !== model_uio()) begin
                failures++;
                $display("FAIL model_uio_out t=%0t got=%h exp=%h", $time, uio_out, model_uio());
            end
            checks++;
            if (uio_oe !== 8'hF0) begin
                failures++;
                $display("FAIL uio_oe t=%0t got=%h exp=f0", $time, uio_oe);
            end
        end
    end

    task automatic lit(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [7:0] dv);
        @(negedge clk);
        ui_in  = dv;
        uio_in = {4'h0, 1'b1, op};
        @(negedge clk);
        uio_in[3] = 1'b0;
    endtask

    initial begin
        int high;
        rst_n  = 0;
        ena    = 1;
        ui_in  = 0;
        uio_in = 0;
        repeat (2) @(negedge clk);
        check_en = 1;
        lit("reset_uo", uo_out, 8'h00);
        lit("reset_flags", uio_out & 8'h70, 8'h10);
`ifndef PWM_OUT_EN
        lit("reset_uio", uio_out, 8'h10);
`endif
        lit("reset_oe", uio_oe, 8'hF0);
        @(negedge clk);
        rst_n = 1;

        // LOAD with one-cycle latency, then STB held high while D changes
        @(negedge clk);
        ui_in  = 8'h3C;
        uio_in = 8'h09;
        @(negedge clk);
        lit("load_latency", uo_out, 8'h3C);
        ui_in = 8'h55;
        repeat (5) @(negedge clk);
        lit("stb_held", uo_out, 8'h3C);
        uio_in = 8'h00;

        do_op(3'b001, 8'hF0);
        do_op(3'b010, 8'h20);
        lit("add_a", uo_out, 8'h10);
        lit("add_c", uio_out & 8'h20, 8'h20);
        do_op(3'b011, 8'h11);
        lit("sub_a", uo_out, 8'hFF);
        lit("sub_flags", uio_out & 8'h70, 8'h60);
`ifndef PWM_OUT_EN
        lit("sub_parity", uio_out & 8'h80, 8'h00);
`endif

        do_op(3'b001, 8'h81);
        do_op(3'b111, 8'h01);
        lit("rol_a", uo_out, 8'h03);
        do_op(3'b110, 8'h03);
        lit("xor_zero", uo_out, 8'h00);
        lit("xor_z", uio_out & 8'h10, 8'h10);
        do_op(3'b001, 8'hFF);
        do_op(3'b010, 8'h02);
        do_op(3'b100, 8'h0F);
        lit("and_a", uo_out, 8'h01);
        lit("and_keeps_c", uio_out & 8'h20, 8'h20);
        do_op(3'b101, 8'hA0);
        lit("or_a", uo_out, 8'hA1);
        lit("or_keeps_c", uio_out & 8'h20, 8'h20);
        do_op(3'b111, 8'h08);
        lit("rol_zero", uo_out, 8'hA1);

        // ena=0 freezes state despite strobes
        ena = 0;
        repeat (3) do_op(3'b001, 8'h77);
        lit("ena_hold", uo_out, 8'hA1);
        ena = 1;
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        lit("midreset_a", uo_out, 8'h00);
        lit("midreset_c", uio_out & 8'h20, 8'h00);
        rst_n = 1;

`ifdef PWM_OUT_EN
        do_op(3'b001, 8'h40);
        high = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (uio_out[7]) high++;
        end
        checks++;
        if (high != 64) begin
            failures++;
            $display("FAIL pwm_duty got=%0d exp=64", high);
        end
`endif

        // Randomized traffic, checked by the compare process
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ui_in  = 8'($urandom);
            uio_in = 8'($urandom);
            ena    = ($urandom_range(0, 9) != 0);
            rst_n  = ($urandom_range(0, 127) != 0);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
